// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel scanning multiplexer.
// Contents:
//   clog2()            - ceiling log2 with a floor of 1, sizes select/index signals
//   ST_MANUAL/ST_SCAN_START/ST_SCAN - FSM state encodings
package mux_pkg;

    // Ceiling log2 with a minimum result of 1 so a select bus is never zero bits.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam logic [1:0] ST_MANUAL     = 2'd0;
    localparam logic [1:0] ST_SCAN_START = 2'd1;
    localparam logic [1:0] ST_SCAN       = 2'd2;

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N-to-1 selector.
// Ports:
//   in_i    [N_CH*W] packed channel data, channel k at [k*W +: W]
//   sel_i   [SEL_W]  channel select
//   y_o     [W]      selected data, zero when sel_i addresses no channel
//   legal_o          sel_i < N_CH
module mux_nx1_comb
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] in_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [W-1:0]      y_o,
    output logic              legal_o
);

    // AND-OR selection; an out-of-range select matches nothing and yields zero.
    always_comb begin
        y_o     = {W{1'b0}};
        legal_o = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            y_o     = y_o | ({W{sel_i == SEL_W'(k)}} & in_i[k*W +: W]);
            legal_o = legal_o | (sel_i == SEL_W'(k));
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit multiplexer with registered output, manual select and
// automatic round-robin scan with a programmable dwell time.
// Ports:
//   clk_i, rst_i (sync, active-high), en_i (clock enable)
//   in_i    [N_CH*W]  packed channel data
//   mode_i            0 = manual, 1 = scan
//   sel_i   [SEL_W]   manual channel select
//   dwell_i [DWELL_W] each scanned channel is held dwell_i+1 cycles
//   out_o   [W]       registered selected data
//   ch_o    [SEL_W]   channel currently driving out_o
//   valid_o           out_o comes from a legal channel
//   wrap_o            one-cycle pulse when the scan wraps N_CH-1 -> 0
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    parameter int SEL_W   = clog2(N_CH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_CH*W-1:0]   in_i,
    input  logic                en_i,
    input  logic                mode_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic [DWELL_W-1:0]  dwell_i,
    output logic [W-1:0]        out_o,
    output logic [SEL_W-1:0]    ch_o,
    output logic                valid_o,
    output logic                wrap_o
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [W-1:0]       out_q, out_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [SEL_W-1:0]   mux_sel_s;
    logic [W-1:0]       mux_y_s;
    logic               mux_legal_s;
    logic               expire_s;
    logic [SEL_W-1:0]   next_ch_s;

    mux_nx1_comb #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_i    (in_i),
        .sel_i   (mux_sel_s),
        .y_o     (mux_y_s),
        .legal_o (mux_legal_s)
    );

    // Dwell expiry and modulo-N_CH successor of the current channel.
    assign expire_s  = (cnt_q == {DWELL_W{1'b0}});
    assign next_ch_s = (ch_q == LAST_CH) ? {SEL_W{1'b0}} : (ch_q + SEL_W'(1));

    // State register plus counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_MANUAL;
            cnt_q   <= {DWELL_W{1'b0}};
            ch_q    <= {SEL_W{1'b0}};
            out_q   <= {W{1'b0}};
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic; dropping mode_i always returns to MANUAL.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            case (state_q)
                ST_MANUAL:     state_d = mode_i ? ST_SCAN_START : ST_MANUAL;
                ST_SCAN_START: state_d = mode_i ? ST_SCAN       : ST_MANUAL;
                ST_SCAN:       state_d = mode_i ? ST_SCAN       : ST_MANUAL;
                default:       state_d = ST_MANUAL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values. A falling mode_i is handled as a manual update,
    // so it takes precedence over a coincident dwell expiry.
    always_comb begin
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        out_d     = out_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        mux_sel_s = ch_q;
        if (en_i) begin
            if (!mode_i) begin
                mux_sel_s = sel_i;
                ch_d      = sel_i;
                out_d     = mux_y_s;
                valid_d   = mux_legal_s;
                cnt_d     = {DWELL_W{1'b0}};
            end else begin
                case (state_q)
                    ST_SCAN_START: begin
                        mux_sel_s = {SEL_W{1'b0}};
                        ch_d      = {SEL_W{1'b0}};
                        out_d     = mux_y_s;
                        valid_d   = 1'b1;
                        cnt_d     = dwell_i;
                    end
                    ST_SCAN: begin
                        if (expire_s) begin
                            mux_sel_s = next_ch_s;
                            ch_d      = next_ch_s;
                            cnt_d     = dwell_i;
                            wrap_d    = (ch_q == LAST_CH);
                        end else begin
                            mux_sel_s = ch_q;
                            ch_d      = ch_q;
                            cnt_d     = cnt_q - DWELL_W'(1);
                        end
                        out_d   = mux_y_s;
                        valid_d = 1'b1;
                    end
                    default: begin
                        // MANUAL (or an illegal encoding) with mode_i=1 still
                        // behaves as manual on the edge that starts the scan.
                        mux_sel_s = sel_i;
                        ch_d      = sel_i;
                        out_d     = mux_y_s;
                        valid_d   = mux_legal_s;
                        cnt_d     = {DWELL_W{1'b0}};
                    end
                endcase
            end
        end else begin
            wrap_d = 1'b0;
        end
    end

    assign out_o   = out_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: a 4-channel and a 3-channel instance
// share clock and controls; expected values are hand-computed.
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  dwell;
    logic [31:0] in_a;
    logic [23:0] in_b;

    logic [7:0]  out_a, out_b;
    logic [1:0]  ch_a, ch_b;
    logic        valid_a, valid_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] da [4];
    logic [7:0] db [3];
    int ch_seq_a [13];
    int ch_seq_b [13];

    always #5 clk = ~clk;

    mux_nx1_scan #(.N_CH(4), .W(8), .DWELL_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_i(in_a), .en_i(en), .mode_i(mode),
        .sel_i(sel), .dwell_i(dwell), .out_o(out_a), .ch_o(ch_a),
        .valid_o(valid_a), .wrap_o(wrap_a)
    );

    mux_nx1_scan #(.N_CH(3), .W(8), .DWELL_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_i(in_b), .en_i(en), .mode_i(mode),
        .sel_i(sel), .dwell_i(dwell), .out_o(out_b), .ch_o(ch_b),
        .valid_o(valid_b), .wrap_o(wrap_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int ch, input logic [7:0] o,
                         input logic v, input logic w);
        chk({tag, ".a.ch"},    32'(ch_a),    32'(ch));
        chk({tag, ".a.out"},   32'(out_a),   32'(o));
        chk({tag, ".a.valid"}, 32'(valid_a), 32'(v));
        chk({tag, ".a.wrap"},  32'(wrap_a),  32'(w));
    endtask

    task automatic chk_b(input string tag, input int ch, input logic [7:0] o,
                         input logic v, input logic w);
        chk({tag, ".b.ch"},    32'(ch_b),    32'(ch));
        chk({tag, ".b.out"},   32'(out_b),   32'(o));
        chk({tag, ".b.valid"}, 32'(valid_b), 32'(v));
        chk({tag, ".b.wrap"},  32'(wrap_b),  32'(w));
    endtask

    initial begin
        da[0] = 8'h11; da[1] = 8'h22; da[2] = 8'h33; da[3] = 8'h44;
        db[0] = 8'h55; db[1] = 8'h66; db[2] = 8'h77;
        ch_seq_a = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        ch_seq_b = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1};
        in_a  = {8'h44, 8'h33, 8'h22, 8'h11};
        in_b  = {8'h77, 8'h66, 8'h55};
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        sel   = 2'd2;
        dwell = 8'd0;

        // Reset state
        tick();
        chk_a("reset", 0, 8'h00, 1'b0, 1'b0);
        chk_b("reset", 0, 8'h00, 1'b0, 1'b0);

        // Test 1: manual select of channel 2
        rst = 1'b0;
        tick();
        chk_a("man_sel2", 2, 8'h33, 1'b1, 1'b0);
        chk_b("man_sel2", 2, 8'h77, 1'b1, 1'b0);

        // Test 2: out-of-range select on the 3-channel instance
        sel = 2'd3;
        tick();
        chk_a("man_sel3", 3, 8'h44, 1'b1, 1'b0);
        chk_b("man_sel3", 3, 8'h00, 1'b0, 1'b0);
        sel = 2'd1;
        chk("latency.a.ch", 32'(ch_a), 32'd3);
        tick();
        chk_a("man_sel1", 1, 8'h22, 1'b1, 1'b0);
        chk_b("man_sel1", 1, 8'h66, 1'b1, 1'b0);

        // Clock enable low in manual mode holds outputs
        en  = 1'b0;
        sel = 2'd2;
        tick();
        chk_a("man_hold", 1, 8'h22, 1'b1, 1'b0);
        en  = 1'b1;

        // Test 3: scan with dwell 2
        sel   = 2'd0;
        mode  = 1'b1;
        dwell = 8'd2;
        tick();
        chk_a("scan_enter", 0, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_a("scan_d2", ch_seq_a[i], da[ch_seq_a[i]], 1'b1, (i == 12));
            chk_b("scan_d2", ch_seq_b[i], db[ch_seq_b[i]], 1'b1, (i == 9));
        end

        // Back to manual, then test 4: scan with dwell 0
        mode = 1'b0;
        tick();
        chk_a("scan_exit", 0, 8'h11, 1'b1, 1'b0);
        mode  = 1'b1;
        dwell = 8'd0;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_a("scan_d0", i % 4, da[i % 4], 1'b1, (i > 0) && (i % 4 == 0));
            chk_b("scan_d0", i % 3, db[i % 3], 1'b1, (i > 0) && (i % 3 == 0));
        end

        // New dwell only applies from the next reload
        dwell = 8'd3;
        tick();
        chk_a("reload_d3", 1, 8'h22, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("dwell_ch1", 1, 8'h22, 1'b1, 1'b0);
        end
        tick();
        chk_a("adv_ch2", 2, 8'h33, 1'b1, 1'b0);
        tick();
        chk_a("dwell_ch2", 2, 8'h33, 1'b1, 1'b0);

        // Test 5: pause for 5 cycles with new channel-2 data
        en = 1'b0;
        in_a[23:16] = 8'hAB;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a("pause", 2, 8'h33, 1'b1, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_a("resume1", 2, 8'hAB, 1'b1, 1'b0);
        tick();
        chk_a("resume2", 2, 8'hAB, 1'b1, 1'b0);
        tick();
        chk_a("resume3", 3, 8'h44, 1'b1, 1'b0);

        // Test 6: reset mid-scan with mode still high
        rst = 1'b1;
        tick();
        chk_a("rst_mid", 0, 8'h00, 1'b0, 1'b0);
        chk_b("rst_mid", 0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_a("restart_man", 0, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a("restart_ch0", 0, 8'h11, 1'b1, 1'b0);
        end
        tick();
        chk_a("restart_ch1", 1, 8'h22, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
